// File: rtl/uart_rx_buffered_pkg.sv
// Shared UART receive definitions: memory-map addresses, RX FSM encodings
// and the line-status word layout read by the memory stage.
package uart_rx_buffered_pkg;

    localparam logic [31:0] UART_RX_ADDR   = 32'hFFFF_0008;
    localparam logic [31:0] UART_STAT_ADDR = 32'hFFFF_000C;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // Status word as presented on a load from UART_STAT_ADDR.
    function automatic logic [31:0] status_word(input logic overrun,
                                                input logic frame_err,
                                                input logic rx_valid);
        return {28'b0, overrun, frame_err, rx_valid};
    endfunction

endpackage

// File: rtl/uart_rx_buffered_if.sv
// Memory-stage side of the UART receiver: pop/clear strobes in, buffered
// byte and line status out.
interface uart_rx_buffered_if #(
    parameter int FIFO_DEPTH = 4
);
    logic                          rd_en;
    logic                          err_clr;
    logic [7:0]                    rd_data;
    logic                          rx_valid;
    logic [$clog2(FIFO_DEPTH):0]   rx_count;
    logic                          frame_err;
    logic                          overrun;

    modport master (
        output rd_en, err_clr,
        input  rd_data, rx_valid, rx_count, frame_err, overrun
    );

    modport slave (
        input  rd_en, err_clr,
        output rd_data, rx_valid, rx_count, frame_err, overrun
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Circular byte buffer for received frames; owns the simultaneous push/pop
// rules so a pop can make room for a push arriving in the same cycle.
module uart_rx_fifo #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  logic [7:0]                  push_data,
    input  logic                        pop,
    output logic [7:0]                  head,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        full,
    output logic                        empty
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(FIFO_DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign count   = count_q;
    assign head    = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage has no reset; head is gated by empty, so stale entries
    // are never visible and the array can map onto plain RAM/LUT storage.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver: pin synchroniser, centred bit timer, frame FSM, sticky
// line-error flags and a small receive FIFO drained by the memory stage.
module uart_rx_buffered
    import uart_rx_buffered_pkg::*;
#(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                uart_rx,
    uart_rx_buffered_if.slave   bus
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int TMR_W        = $clog2(CLKS_PER_BIT);
    localparam logic [TMR_W-1:0] HALF_LAST = TMR_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TMR_W-1:0] BIT_LAST  = TMR_W'(CLKS_PER_BIT - 1);

    logic                        rx_meta;
    logic                        rxs;
    rx_state_t                   state;
    logic [TMR_W-1:0]            bit_cnt;
    logic [2:0]                  bit_idx;
    logic [7:0]                  shift;
    logic                        frame_err_q;
    logic                        overrun_q;
    logic                        stop_sample;
    logic                        set_frame_err;
    logic                        set_overrun;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    // NOTE: non-blocking assignments let both flops sample the previous
    // value of their source on the same edge, forming a true 2-stage chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= RX_IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            case (state)
                RX_IDLE: begin
                    bit_cnt <= '0;
                    if (!rxs) state <= RX_START;
                end
                RX_START: begin
                    if (bit_cnt == HALF_LAST) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        state   <= rxs ? RX_IDLE : RX_DATA;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt        <= '0;
                        shift[bit_idx] <= rxs;
                        bit_idx        <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) state <= RX_STOP;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    // Leave mid stop bit so a back-to-back start edge is seen.
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        state   <= RX_IDLE;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

    assign stop_sample   = (state == RX_STOP) && (bit_cnt == BIT_LAST);
    assign set_frame_err = stop_sample && !rxs;
    // A pop landing on the stop sample frees a slot, so a full FIFO only
    // overruns when the memory stage is not reading in that same cycle.
    assign set_overrun   = stop_sample && rxs && fifo_full && !bus.rd_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (set_frame_err)    frame_err_q <= 1'b1;
            else if (bus.err_clr) frame_err_q <= 1'b0;
            if (set_overrun)      overrun_q   <= 1'b1;
            else if (bus.err_clr) overrun_q   <= 1'b0;
        end
    end

    uart_rx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (stop_sample && rxs),
        .push_data (shift),
        .pop       (bus.rd_en),
        .head      (bus.rd_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bus.rx_valid  = !fifo_empty;
    assign bus.rx_count  = fifo_count;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;

endmodule
